// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_arbiter
// Description : Round-robin scheduler that shares one combinational IEEE-754
//               single-precision multiplier among NUM_REQ requesters. Each
//               accepted operand pair passes through an operand register
//               (stage 1) and a result register (stage 2). Full backpressure
//               is supported, and results are tagged with the issuing
//               requester's index.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_REQ   number of requesters (2..16)
//   ID_W      width of res_id, max(1, ceil(log2(NUM_REQ)))
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand-pair valid
//   req_a      packed operand A, requester i at [32i+31:32i]
//   req_b      packed operand B, same packing
//   req_ready  one-hot (or zero) accept strobe
//   res_valid  result register holds a product
//   res_ready  consumer accepts the result
//   res_data   product
//   res_id     index of the requester that issued the product
//   busy       either pipeline stage is occupied
//   op_count   delivered products, wraps at 2^32
// ============================================================================
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy,
    output logic [31:0]           op_count
);

    // Truncating single-precision multiply. Zero exponents flush to a signed
    // zero, all-ones exponents (infinity or NaN) give a signed infinity, and
    // results whose exponent underflows flush to a signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [47:0] prod;
        logic [9:0]  exp_sum;
        logic [22:0] mant;
        sign    = a[31] ^ b[31];
        ea      = a[30:23];
        eb      = b[30:23];
        prod    = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        // Biased sum, plus one when the mantissa product carries into bit 47.
        // Bit 9 set means the sum went negative.
        exp_sum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} - 10'd127;
        mant    = prod[47] ? prod[46:24] : prod[45:23];
        if ((ea == 8'h00) || (eb == 8'h00)) begin
            fp_mul = {sign, 31'd0};
        end else if ((ea == 8'hFF) || (eb == 8'hFF)) begin
            fp_mul = {sign, 8'hFF, 23'd0};
        end else if (!exp_sum[9] && (exp_sum >= 10'd255)) begin
            fp_mul = {sign, 8'hFF, 23'd0};
        end else if (exp_sum[9] || (exp_sum == 10'd0)) begin
            fp_mul = {sign, 31'd0};
        end else begin
            fp_mul = {sign, exp_sum[7:0], mant};
        end
    endfunction

    // Stage 1: operand register
    logic            s1_valid;
    logic [31:0]     s1_a;
    logic [31:0]     s1_b;
    logic [ID_W-1:0] s1_id;

    // Stage 2: result register
    logic            s2_valid;
    logic [31:0]     s2_data;
    logic [ID_W-1:0] s2_id;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] ptr_after_grant;
    logic            s2_load;
    logic            s1_free;
    logic            accept;
    logic [31:0]     mul_out;

    assign s2_load = s1_valid && (!s2_valid || res_ready);
    assign s1_free = !s1_valid || s2_load;
    assign accept  = s1_free && (|req_valid);

    // Scan from the farthest offset back to rr_ptr so that the requester
    // closest to rr_ptr (in rotation order) is the final, winning assignment.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                grant = ID_W'(idx);
            end
        end
    end

    assign ptr_after_grant = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign mul_out = fp_mul(s1_a, s1_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (accept) begin
                s1_a     <= req_a[32*grant +: 32];
                s1_b     <= req_b[32*grant +: 32];
                s1_id    <= grant;
                s1_valid <= 1'b1;
                rr_ptr   <= ptr_after_grant;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Data and id are only rewritten on a load, so a drained result keeps
    // its last value on res_data/res_id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else begin
            if (s2_load) begin
                s2_data  <= mul_out;
                s2_id    <= s1_id;
                s2_valid <= 1'b1;
            end else if (s2_valid && res_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_valid && res_ready) begin
            op_count <= op_count + 32'd1;
        end
    end

    assign res_valid = s2_valid;
    assign res_data  = s2_data;
    assign res_id    = s2_id;
    assign busy      = s1_valid | s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_arbiter
// Description : Directed testbench for fp_mul_arbiter (NUM_REQ=4). Inputs are
//               driven 1 time unit after the rising edge; outputs are sampled
//               1-2 time units after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [31:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  busy;
    logic [31:0]           op_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] data, input int id);
        chk({tag, ".valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".data"},  res_data, data);
        chk({tag, ".id"},    32'(res_id), 32'(id));
    endtask

    // Special-value vectors for requester 2
    logic [31:0] sp_a [4] = '{32'h3FC00000, 32'h00000000, 32'h7F800000, 32'h7F000000};
    logic [31:0] sp_b [4] = '{32'hC0000000, 32'h40000000, 32'h3F800000, 32'h7F000000};
    logic [31:0] sp_p [4] = '{32'hC0400000, 32'h00000000, 32'h7F800000, 32'h7F800000};

    // Round robin: A = 2.0 for everyone, B = 1.0/2.0/3.0/4.0 by requester
    logic [31:0] rr_b [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] rr_p [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

    // Sparse: grant order from rr_ptr = 2 with requesters 1 and 3 valid
    int          sp_g [4] = '{3, 1, 3, 1};

    // Backpressure timeline, one entry per cycle
    int bp_offer [10] = '{0, 1, 2, 2, 2, 2, 3, -1, -1, -1};
    int bp_rr    [10] = '{1, 1, 0, 0, 0, 1, 1,  1,  1,  1};
    int bp_rdy   [10] = '{1, 1, 0, 0, 0, 1, 1,  0,  0,  0};
    int bp_res   [10] = '{-1, -1, 0, 0, 0, 0, 1, 2,  3, -1};

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.res_data",  res_data, 32'd0);
        chk("rst.res_id",    32'(res_id), 32'd0);
        chk("rst.busy",      32'(busy), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.op_count",  op_count, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- single op: 2.0 * 3.0 from requester 0 ----------------
        set_req(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        chk("single.req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("single.mid_valid", 32'(res_valid), 32'd0);
        chk("single.mid_busy",  32'(busy), 32'd1);
        tick();
        chk_res("single.res", 32'h40C00000, 0);
        tick();
        chk("single.done_valid", 32'(res_valid), 32'd0);
        chk("single.op_count",   op_count, 32'd1);
        chk("single.busy",       32'(busy), 32'd0);

        // ---------------- special values, requester 2 back-to-back ----------------
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                set_req(2, sp_a[i], sp_b[i]);
                req_valid = 4'b0100;
            end else begin
                req_valid = '0;
            end
            #1;
            if (i < 4) chk($sformatf("special.ready%0d", i), 32'(req_ready), 32'h4);
            if (i >= 2) chk_res($sformatf("special.res%0d", i - 2), sp_p[i-2], 2);
            tick();
        end
        chk("special.drained", 32'(res_valid), 32'd0);
        chk("special.op_count", op_count, 32'd5);

        // ---------------- requester 3: -1.0 * 1.0, moves rr_ptr 3 -> 0 ----------------
        set_req(3, 32'h3F800000, 32'hBF800000);
        req_valid = 4'b1000;
        #1;
        chk("wrap.req_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk_res("wrap.res", 32'hBF800000, 3);
        tick();

        // ---------------- round robin, all four valid ----------------
        for (int r = 0; r < 4; r++) set_req(r, 32'h40000000, rr_b[r]);
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 6) ? 4'b1111 : 4'b0000;
            #1;
            if (i < 6) chk($sformatf("rr.grant%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            if (i >= 2) chk_res($sformatf("rr.res%0d", i - 2), rr_p[(i-2) % 4], (i - 2) % 4);
            tick();
        end
        chk("rr.drained",  32'(res_valid), 32'd0);
        chk("rr.op_count", op_count, 32'd12);

        // ---------------- sparse: requesters 1 and 3, rr_ptr = 2 ----------------
        set_req(1, 32'h40000000, 32'h40000000);
        set_req(3, 32'h40000000, 32'h40800000);
        for (int i = 0; i < 6; i++) begin
            req_valid = (i < 4) ? 4'b1010 : 4'b0000;
            #1;
            if (i < 4) chk($sformatf("sparse.grant%0d", i), 32'(req_ready), 32'(1 << sp_g[i]));
            if (i >= 2) chk_res($sformatf("sparse.res%0d", i - 2),
                                (sp_g[i-2] == 1) ? 32'h40800000 : 32'h41000000, sp_g[i-2]);
            tick();
        end
        chk("sparse.op_count", op_count, 32'd16);

        // ---------------- backpressure, requester 0 streaming ----------------
        for (int i = 0; i < 10; i++) begin
            if (bp_offer[i] >= 0) begin
                set_req(0, 32'h40000000, rr_b[bp_offer[i]]);
                req_valid = 4'b0001;
            end else begin
                req_valid = '0;
            end
            res_ready = (bp_rr[i] != 0);
            #1;
            chk($sformatf("bp.ready%0d", i), 32'(req_ready), 32'(bp_rdy[i]));
            if (bp_res[i] >= 0) begin
                chk_res($sformatf("bp.res%0d", i), rr_p[bp_res[i]], 0);
            end else begin
                chk($sformatf("bp.idle%0d", i), 32'(res_valid), 32'd0);
            end
            if (i == 4) chk("bp.stall_count", op_count, 32'd16);
            tick();
        end
        chk("bp.op_count", op_count, 32'd20);
        chk("bp.busy",     32'(busy), 32'd0);

        // ---------------- async reset with both stages full ----------------
        res_ready = 1'b0;
        set_req(0, 32'h40000000, 32'h3F800000);
        req_valid = 4'b0001;
        tick();
        set_req(0, 32'h40000000, 32'h40000000);
        tick();
        set_req(0, 32'h40000000, 32'h40400000);
        #1;
        chk("arst.full_ready", 32'(req_ready), 32'd0);
        chk("arst.full_valid", 32'(res_valid), 32'd1);
        chk("arst.full_busy",  32'(busy), 32'd1);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.res_valid", 32'(res_valid), 32'd0);
        chk("arst.res_data",  res_data, 32'd0);
        chk("arst.res_id",    32'(res_id), 32'd0);
        chk("arst.busy",      32'(busy), 32'd0);
        chk("arst.op_count",  op_count, 32'd0);
        chk("arst.req_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        chk("arst.no_stale", 32'(res_valid), 32'd0);
        set_req(1, 32'h40400000, 32'h40400000);
        req_valid = 4'b0010;
        #1;
        chk("arst.req_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk_res("arst.res", 32'h41100000, 1);
        tick();
        chk("arst.op_count1", op_count, 32'd1);
        chk("arst.busy_end",  32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Round-robin scheduler that shares one combinational FloatingMultiplication instance among NUM_REQ requesters, for example neuron lanes in a layer. It accepts one operand pair per cycle through per-requester valid/ready handshakes. Operands pass through a registered operand stage and a registered result stage, with full backpressure. Each result is returned tagged with the ID of the requester that issued it.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
ID_W, 2, width of res_id; must equal max(1, ceil(log2(NUM_REQ))).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  bit i: requester i presents an operand pair.
req_a  input  32*NUM_REQ  IEEE-754 single operand A; requester i uses bits [32i+31:32i].
req_b  input  32*NUM_REQ  operand B, same packing as req_a.
req_ready  output  NUM_REQ  one-hot or zero; bit i high means requester i's pair is accepted this cycle.
res_valid  output  1  result stage holds a valid product.
res_ready  input  1  consumer accepts the result.
res_data  output  32  product as computed by FloatingMultiplication.
res_id  output  ID_W  index of the requester that issued the product.
busy  output  1  high when either pipeline stage is valid.
op_count  output  32  number of products delivered (res_valid && res_ready); wraps at 2^32.

Behaviour:
- Reset (asynchronous assert, synchronous release): s1_valid=0, s2_valid=0, rr_ptr=0, op_count=0.
  - Resulting outputs: res_valid=0, res_data=0, res_id=0, busy=0, req_ready=0.
  - Reset mid-operation discards any in-flight pairs; no result for them is ever emitted.
- Stage 1 (operand register) holds s1_a, s1_b, s1_id and s1_valid. Its outputs feed the multiplier instance.
- Stage 2 (result register) holds s2_data, s2_id and s2_valid. It drives res_valid, res_data and res_id directly.
- Advance conditions:
  - s2_load = s1_valid && (!s2_valid || res_ready).
  - s1_free = !s1_valid || s2_load.
- Arbitration is combinational.
  - grant = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - accept = s1_free && |req_valid.
  - req_ready[grant] = accept; all other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - A requester must hold req_valid and its operands stable until it sees req_ready.
- On accept: load s1 with {req_a[grant], req_b[grant], grant}, set s1_valid=1, and set rr_ptr=(grant+1) mod NUM_REQ.
  - With no accept, rr_ptr holds.
- On s2_load: s2_data = multiplier(s1_a, s1_b), s2_id = s1_id, s2_valid = 1.
- If res_valid && res_ready && !s2_load: s2_valid=0. In the same case, res_data and res_id keep their last values.
- If s1_valid && s2_load && !accept: s1_valid=0.
- Simultaneous events: deliver, advance and accept can all occur in one cycle, giving sustained throughput of 1 product per clock.
- Latency: a pair accepted at edge k appears on res_valid after edge k+1, provided stage 2 is not stalled. That is 2 clocks from request cycle to result cycle.
- Backpressure:
  - While res_ready=0 and res_valid=1, res_data and res_id are stable.
  - At most 2 pairs are in flight; once both stages are full, req_ready=0.
- Ordering: results leave in acceptance order.
- Arithmetic follows FloatingMultiplication exactly; no additional rounding or special-case handling here:
  - either exponent 0 gives a signed zero;
  - either exponent 0xFF gives a signed infinity (NaN inputs also give infinity);
  - a biased-exponent overflow gives infinity;
  - the mantissa is truncated.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- op_count increments when res_valid && res_ready.
- busy = s1_valid | s2_valid.

Test Plan:
- Single op: req 0, A=0x40000000 (2.0), B=0x40400000 (3.0), res_ready=1 -> res_valid 2 cycles later with res_data=0x40C00000 and res_id=0; op_count=1; busy returns to 0.
- Special values, issued by requester 2 back-to-back:
  - 0x3FC00000 * 0xC0000000 -> 0xC0400000
  - 0x00000000 * 0x40000000 -> 0x00000000
  - 0x7F800000 * 0x3F800000 -> 0x7F800000
  - 0x7F000000 * 0x7F000000 -> 0x7F800000 (overflow)
  - Required: all four results on consecutive cycles, in that order, with res_id=2.
- Round robin: all 4 req_valid held high, res_ready=1 -> grants 0,1,2,3,0,1... one per cycle; res_id follows the same sequence starting 2 cycles later.
- Backpressure: pipeline streaming, drop res_ready for 3 cycles -> res_data and res_id frozen; req_ready=0 after 2 items are buffered; on release, no result is lost or duplicated; op_count matches the number of accepts.
- Sparse requests: only req_valid[3] and req_valid[1] active, with rr_ptr=2 -> grant order 3,1,3,1; rr_ptr wraps from 3 to 0 correctly.
- Async reset: assert rst_n=0 with both stages full, between clock edges -> all outputs reach reset values immediately; after release, the first new request completes normally and op_count restarts at 0.
